pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Parametrised successor to the program counter: AW-bit PC with absolute load, signed relative branch, increment, and a hardware call/return stack of depth SD.
- Includes a micro-step sequencer (is) with configurable step count, plus a tri-stated address bus output.
- Sits in the ECU between the instruction decoder (control strobes) and the shared address bus.

Parameters:
AW, 16, PC / address width in bits
SD, 8, call-stack depth in entries (power of two, >=2)
SW, 3, micro-step counter width
STEPS, 6, number of micro-steps per instruction (2..2^SW)
RST_VEC, 0, PC value after reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low (state cleared while rst=0)
ai  in  AW  address input: load/call target, or signed offset for relative branch
lrc  in  1  load PC absolute from ai
lrl  in  1  load PC relative: PC <= PC + signed(ai)
ini  in  1  increment PC by 1
cal  in  1  call: push PC+1, PC <= ai
ret  in  1  return: pop top of stack into PC
cub  in  1  clear micro-step counter to 0
stp  in  1  advance micro-step counter
oe  in  1  output enable for ao
ao  out  AW  PC onto the address bus; high-Z when oe=0
is  out  SW  current micro-step
pc_q  out  AW  PC, always driven (debug/decoder use)
sp  out  log2(SD)+1  stack occupancy, 0..SD
full  out  1  sp==SD
empty  out  1  sp==0
err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset (rst=0, async): PC=RST_VEC, is=0, sp=0, err=0, stack contents don't-care. Outputs: pc_q=RST_VEC, is=0, sp=0, full=0, empty=1, err=0. ao is high-Z unless oe=1, in which case it drives RST_VEC. Leaving reset is synchronous to the next edge; no update occurs on the edge during which rst=0.
- PC operations: at most one per cycle, resolved by fixed priority ret > cal > lrc > lrl > ini. Lower-priority strobes asserted in the same cycle are ignored. No strobe: PC holds.
- ini: PC <= PC+1 modulo 2^AW. 0xFFFF wraps to 0x0000 for AW=16.
- lrl: PC <= (PC + ai) mod 2^AW, ai treated as two's complement. 0x0004 + 0xFFFE gives 0x0002.
- cal, not full: stack[sp] <= (PC+1) mod 2^AW, sp <= sp+1, PC <= ai.
- cal, full: PC, stack and sp unchanged; err <= 1.
- ret, not empty: PC <= stack[sp-1], sp <= sp-1.
- ret, empty: PC and sp unchanged; err <= 1.
- err is sticky and clears only on reset.
- full and empty are combinational from sp. Single-cycle latency: new PC is visible on pc_q/ao immediately after the edge.
- Micro-step counter:
  - cub has priority and sets is <= 0.
  - Else stp advances is <= is+1, or is <= 0 when is==STEPS-1.
  - Else is holds.
  - Independent of PC operations; both may act in the same cycle.
- ao = oe ? PC : 'z. Purely combinational, no clock latency on oe.
- Async reset mid-operation (e.g. during a cal edge) aborts the update entirely; post-reset state is as above.

Test Plan:
- Reset, oe=1, 3 cycles ini -> ao=0x0003. oe=0 -> ao=zzzz and pc_q=0x0003. rst pulse low -> pc_q=0x0000, is=0, empty=1.
- ai=0x800A with lrc for 1 cycle -> pc_q=0x800A. Then ai=0xFFFE with lrl -> 0x8008. Then ai=0x0010 with lrl -> 0x8018.
- Starting from PC=0x0100: cal ai=0x2000 -> PC=0x2000, sp=1. cal ai=0x3000 -> PC=0x3000, sp=2. ret -> PC=0x2001, sp=1. ret -> PC=0x0101, sp=0, empty=1.
- SD=8: 8 cals -> full=1, sp=8. 9th cal with ai=0x5555 -> PC unchanged, err=1. 8 rets -> empty. 9th ret -> PC unchanged, err stays 1 until reset.
- PC=0xFFFF, ini -> 0x0000. Simultaneous ret+cal+ini with sp=1, top=0x1234 -> PC=0x1234, sp=0 (ret wins).
- stp held 7 cycles with STEPS=6 -> is sequence 1,2,3,4,5,0,1. cub+stp in the same cycle -> is=0.

Source files
------------

// File: rtl/pc_stack.sv
// Program counter with absolute/relative load, increment, a call/return stack
// and a micro-step sequencer; PC is also driven onto a tri-stated address bus.
module pc_stack #(
  parameter int              AW      = 16,
  parameter int              SD      = 8,
  parameter int              SW      = 3,
  parameter int              STEPS   = 6,
  parameter logic [AW-1:0]   RST_VEC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         ai,
  input  logic                  lrc,
  input  logic                  lrl,
  input  logic                  ini,
  input  logic                  cal,
  input  logic                  ret,
  input  logic                  cub,
  input  logic                  stp,
  input  logic                  oe,
  output logic [AW-1:0]         ao,
  output logic [SW-1:0]         is,
  output logic [AW-1:0]         pc_q,
  output logic [$clog2(SD):0]   sp,
  output logic                  full,
  output logic                  empty,
  output logic                  err
);

  localparam int IW  = $clog2(SD);
  localparam int SPW = IW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(SD);
  localparam logic [SW-1:0]  IS_LAST = SW'(STEPS - 1);

  // Two's-complement offset added to the PC, wrapping modulo 2^AW.
  function automatic logic [AW-1:0] f_add_wrap(input logic [AW-1:0]        base,
                                               input logic signed [AW-1:0] off);
    logic signed [AW-1:0] sum;
    sum = $signed(base) + off;
    return $unsigned(sum);
  endfunction

  logic [AW-1:0]  r_pc;
  logic [SPW-1:0] r_sp;
  logic           r_err;
  logic [SW-1:0]  r_is;
  logic [AW-1:0]  r_stk [SD];

  logic [AW-1:0]        w_pc_nxt;
  logic [AW-1:0]        w_pc_inc;
  logic [AW-1:0]        w_pc_rel;
  logic [AW-1:0]        w_top;
  logic signed [AW-1:0] w_off;
  logic [SPW-1:0]       w_sp_nxt;
  logic [IW-1:0]        w_wr_idx;
  logic [IW-1:0]        w_rd_idx;
  logic [SW-1:0]        w_is_nxt;
  logic                 w_err_set;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;

  assign w_full   = (r_sp == SP_FULL);
  assign w_empty  = (r_sp == '0);
  assign w_off    = $signed(ai);
  assign w_pc_inc = f_add_wrap(r_pc, AW'(signed'(1)));
  assign w_pc_rel = f_add_wrap(r_pc, w_off);
  assign w_wr_idx = r_sp[IW-1:0];
  // With sp==SD the low bits are zero, so the decrement lands on SD-1.
  assign w_rd_idx = r_sp[IW-1:0] - IW'(1);
  assign w_top    = r_stk[w_rd_idx];

  // PC operation select: ret > cal > lrc > lrl > ini
  always_comb begin
    w_pc_nxt  = r_pc;
    w_sp_nxt  = r_sp;
    w_err_set = 1'b0;
    w_push    = 1'b0;
    if (ret) begin
      if (!w_empty) begin
        w_pc_nxt = w_top;
        w_sp_nxt = r_sp - SPW'(1);
      end else begin
        w_err_set = 1'b1;
      end
    end else if (cal) begin
      if (!w_full) begin
        w_push   = 1'b1;
        w_pc_nxt = ai;
        w_sp_nxt = r_sp + SPW'(1);
      end else begin
        w_err_set = 1'b1;
      end
    end else if (lrc) begin
      w_pc_nxt = ai;
    end else if (lrl) begin
      w_pc_nxt = w_pc_rel;
    end else if (ini) begin
      w_pc_nxt = w_pc_inc;
    end
  end

  always_comb begin
    w_is_nxt = r_is;
    if (cub) begin
      w_is_nxt = '0;
    end else if (stp) begin
      w_is_nxt = (r_is == IS_LAST) ? '0 : r_is + SW'(1);
    end
  end

  // Control state register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= RST_VEC;
      r_sp  <= '0;
      r_err <= 1'b0;
      r_is  <= '0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_sp  <= w_sp_nxt;
      r_err <= r_err | w_err_set;
      r_is  <= w_is_nxt;
    end
  end

  // Stack storage carries no reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_stk[w_wr_idx] <= w_pc_inc;
    end
  end

  assign pc_q  = r_pc;
  assign ao    = oe ? r_pc : {AW{1'bz}};
  assign is    = r_is;
  assign sp    = r_sp;
  assign full  = w_full;
  assign empty = w_empty;
  assign err   = r_err;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack: directed vector table, hand-written corner sequences and
// randomized strobes, all compared against a queue-based reference model.
module tb_pc_stack;

  localparam int AW    = 16;
  localparam int SD    = 8;
  localparam int SW    = 3;
  localparam int STEPS = 6;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ai;
  logic          lrc, lrl, ini, cal, ret, cub, stp, oe;
  wire  [AW-1:0] ao;
  logic [SW-1:0] is;
  logic [AW-1:0] pc_q;
  logic [3:0]    sp;
  logic          full, empty, err;

  pc_stack #(.AW(AW), .SD(SD), .SW(SW), .STEPS(STEPS), .RST_VEC(16'h0000)) dut (
    .clk(clk), .rst(rst), .ai(ai), .lrc(lrc), .lrl(lrl), .ini(ini), .cal(cal),
    .ret(ret), .cub(cub), .stp(stp), .oe(oe), .ao(ao), .is(is), .pc_q(pc_q),
    .sp(sp), .full(full), .empty(empty), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;

  // Reference model: PC as an integer, the call stack as a queue.
  int            m_pc;
  int            m_is;
  bit            m_err;
  logic [AW-1:0] m_stk [$];

  typedef struct {
    logic [6:0]    strb;  // {ret,cal,lrc,lrl,ini,cub,stp}
    logic [AW-1:0] ai;
    logic [AW-1:0] pc;
    logic [3:0]    sp;
    logic [SW-1:0] isv;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic [6:0] strb, input logic [AW-1:0] a,
                              input logic [AW-1:0] pc, input logic [3:0] s,
                              input logic [SW-1:0] isv);
    vec_t v;
    v.strb = strb; v.ai = a; v.pc = pc; v.sp = s; v.isv = isv;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tot++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_is  = 0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_step();
    int mask;
    mask = (1 << AW) - 1;
    if (!rst) begin
      model_reset();
    end else begin
      if (ret) begin
        if (m_stk.size() > 0) m_pc = int'(m_stk.pop_back());
        else m_err = 1'b1;
      end else if (cal) begin
        if (m_stk.size() < SD) begin
          m_stk.push_back(AW'((m_pc + 1) & mask));
          m_pc = int'(ai);
        end else m_err = 1'b1;
      end else if (lrc) m_pc = int'(ai);
      else if (lrl) m_pc = (m_pc + int'($signed(ai))) & mask;
      else if (ini) m_pc = (m_pc + 1) & mask;
      if (cub) m_is = 0;
      else if (stp) m_is = (m_is + 1) % STEPS;
    end
  endtask

  task automatic check_all();
    chk("pc_q",  int'(pc_q),  m_pc);
    chk("sp",    int'(sp),    m_stk.size());
    chk("is",    int'(is),    m_is);
    chk("err",   int'(err),   int'(m_err));
    chk("full",  int'(full),  int'(m_stk.size() == SD));
    chk("empty", int'(empty), int'(m_stk.size() == 0));
    if (oe) chk("ao", int'(ao), m_pc);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic clr();
    {ret, cal, lrc, lrl, ini, cub, stp} = 7'b0;
    ai = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    oe  = 1'b0;
    clr();
    #2;
    do_reset();

    // Increment, bus drive and release, async reset pulse
    oe  = 1'b1;
    ini = 1'b1;
    repeat (3) cyc();
    ini = 1'b0;
    chk("ao_after_3ini", int'(ao), 16'h0003);
    oe = 1'b0;
    #1;
    chk("ao_released", int'(ao === pc_q), 0);
    chk("pcq_oe0", int'(pc_q), 16'h0003);
    do_reset();
    chk("rst_pc", int'(pc_q), 0);
    chk("rst_is", int'(is), 0);
    chk("rst_empty", int'(empty), 1);

    // Directed vector table, starting from PC=0
    tbl.push_back(mk(7'b0010000, 16'h800A, 16'h800A, 4'd0, 3'd0));
    tbl.push_back(mk(7'b0001000, 16'hFFFE, 16'h8008, 4'd0, 3'd0));
    tbl.push_back(mk(7'b0001000, 16'h0010, 16'h8018, 4'd0, 3'd0));
    tbl.push_back(mk(7'b0010000, 16'h0100, 16'h0100, 4'd0, 3'd0));
    tbl.push_back(mk(7'b0100000, 16'h2000, 16'h2000, 4'd1, 3'd0));
    tbl.push_back(mk(7'b0100000, 16'h3000, 16'h3000, 4'd2, 3'd0));
    tbl.push_back(mk(7'b1000000, 16'h0000, 16'h2001, 4'd1, 3'd0));
    tbl.push_back(mk(7'b1000000, 16'h0000, 16'h0101, 4'd0, 3'd0));
    tbl.push_back(mk(7'b0010000, 16'hFFFF, 16'hFFFF, 4'd0, 3'd0));
    tbl.push_back(mk(7'b0000100, 16'h0000, 16'h0000, 4'd0, 3'd0));
    tbl.push_back(mk(7'b0010000, 16'h1233, 16'h1233, 4'd0, 3'd0));
    tbl.push_back(mk(7'b0100000, 16'h0500, 16'h0500, 4'd1, 3'd0));
    tbl.push_back(mk(7'b1110100, 16'h7777, 16'h1234, 4'd0, 3'd0));
    tbl.push_back(mk(7'b0000001, 16'h0000, 16'h1234, 4'd0, 3'd1));
    tbl.push_back(mk(7'b0000001, 16'h0000, 16'h1234, 4'd0, 3'd2));
    tbl.push_back(mk(7'b0000001, 16'h0000, 16'h1234, 4'd0, 3'd3));
    tbl.push_back(mk(7'b0000001, 16'h0000, 16'h1234, 4'd0, 3'd4));
    tbl.push_back(mk(7'b0000001, 16'h0000, 16'h1234, 4'd0, 3'd5));
    tbl.push_back(mk(7'b0000001, 16'h0000, 16'h1234, 4'd0, 3'd0));
    tbl.push_back(mk(7'b0000001, 16'h0000, 16'h1234, 4'd0, 3'd1));
    tbl.push_back(mk(7'b0000011, 16'h0000, 16'h1234, 4'd0, 3'd0));
    tbl.push_back(mk(7'b0001001, 16'hFFFC, 16'h1230, 4'd0, 3'd1));
    foreach (tbl[i]) begin
      {ret, cal, lrc, lrl, ini, cub, stp} = tbl[i].strb;
      ai = tbl[i].ai;
      cyc();
      chk($sformatf("tbl%0d_pc", i), int'(pc_q), int'(tbl[i].pc));
      chk($sformatf("tbl%0d_sp", i), int'(sp),   int'(tbl[i].sp));
      chk($sformatf("tbl%0d_is", i), int'(is),   int'(tbl[i].isv));
      chk($sformatf("tbl%0d_err", i), int'(err), 0);
    end
    clr();

    // Overflow and underflow of the call stack
    do_reset();
    for (int i = 0; i < SD; i++) begin
      cal = 1'b1;
      ai  = AW'(16'h1000 + i);
      cyc();
    end
    chk("ovf_full", int'(full), 1);
    chk("ovf_sp", int'(sp), SD);
    chk("ovf_err_pre", int'(err), 0);
    ai = 16'h5555;
    cyc();
    chk("ovf_pc_hold", int'(pc_q), 16'h1007);
    chk("ovf_err", int'(err), 1);
    cal = 1'b0;
    ret = 1'b1;
    repeat (SD) cyc();
    chk("unf_empty", int'(empty), 1);
    chk("unf_pc", int'(pc_q), 16'h0001);
    cyc();
    chk("unf_pc_hold", int'(pc_q), 16'h0001);
    chk("unf_err_sticky", int'(err), 1);
    clr();
    repeat (3) cyc();
    chk("err_still_set", int'(err), 1);
    do_reset();
    chk("err_cleared", int'(err), 0);

    // Reset asserted during a call edge aborts the call
    lrc = 1'b1; ai = 16'h0777; cyc();
    clr();
    cal = 1'b1; ai = 16'hABCD; stp = 1'b1;
    #3;
    rst = 1'b0;
    cyc();
    chk("midcal_pc", int'(pc_q), 0);
    chk("midcal_sp", int'(sp), 0);
    rst = 1'b1;
    clr();
    cyc();

    // Randomized strobes against the model
    for (int i = 0; i < 800; i++) begin
      ret = ($urandom_range(0, 3) == 0);
      cal = ($urandom_range(0, 3) == 0);
      lrc = ($urandom_range(0, 5) == 0);
      lrl = ($urandom_range(0, 3) == 0);
      ini = ($urandom_range(0, 1) == 0);
      cub = ($urandom_range(0, 7) == 0);
      stp = ($urandom_range(0, 1) == 0);
      oe  = ($urandom_range(0, 1) == 0);
      ai  = AW'($urandom);
      if (i == 400) do_reset();
      else cyc();
    end
    clr();
    oe = 1'b0;
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
